bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter for the single-ported 16-bit processor bus (RAM 0x000–0x1FF, button 0x900/0x901, seven-segment 0xB00).
- Master 0 is the bird CPU. Master 1 is a secondary agent (loader/DMA).
- Grants the bus to one master at a time: round-robin between masters, bounded burst length, registered grants.
- Drives the shared address, write-data and write-strobe lines that feed the existing decode and RAM write logic.

Parameters:
- ADDR_W, 12, bus address width.
- DATA_W, 16, bus data width.
- MAX_BURST, 4, maximum consecutive beats one master may hold while the other is requesting (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 requests the bus.
- m0_we  in  1  master 0 write strobe.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 owns the bus this cycle.
- m0_rdata  out  DATA_W  read data to master 0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata: same as master 0, for master 1.
- bus_addr  out  ADDR_W  shared address to decode.
- bus_wdata  out  DATA_W  shared write data.
- bus_we  out  1  shared write strobe (memwt).
- bus_rdata  in  DATA_W  decoded read data from RAM/peripherals.
- bus_owner  out  1  index of current owner; valid only when a gnt is high.

Behaviour:
- States: IDLE, OWN0, OWN1. Internal state: registered `last` pointer and burst counter `cnt` of width $clog2(MAX_BURST+1).
- Reset values (asynchronous):
  - state=IDLE, m0_gnt=m1_gnt=0.
  - last=1, so master 0 wins the first tie.
  - cnt=0, bus_owner=0.
- Grant outputs:
  - m0_gnt = (state==OWN0); m1_gnt = (state==OWN1). Both are decoded directly from registered state and are never high together.
- Beats:
  - A beat is a cycle with mX_gnt & mX_req.
  - bus_we = mX_we & mX_gnt & mX_req. A granted master that has dropped req never writes.
- Bus muxing:
  - bus_addr/bus_wdata follow the owner combinationally.
  - In IDLE, bus_addr=0, bus_wdata=0, bus_we=0.
- Read data:
  - m0_rdata = m1_rdata = bus_rdata.
  - Read data is meaningful only in a beat. Reads complete in the beat cycle (zero wait states).
- Latency: req asserted in cycle N with the bus IDLE → gnt high in cycle N+1. No combinational req→gnt path.
- IDLE transitions:
  - Only one master requesting → OWN of that master.
  - Both requesting → OWN of the master ≠ last.
  - None requesting → stay IDLE.
- OWNx transitions (y = other master), evaluated each edge:
  - mX_req=0 & my_req=1 → OWNy.
  - mX_req=0 & my_req=0 → IDLE.
  - mX_req=1 & my_req=1 & cnt==MAX_BURST-1 → OWNy (forced yield, no idle gap).
  - Otherwise stay OWNx.
- On every entry into OWNx: last←x, cnt←0.
- Counter:
  - While staying in OWNx with a beat, cnt increments.
  - cnt saturates at MAX_BURST-1 when the other master is not requesting; the owner then keeps the bus indefinitely.
- Handoff: exactly one cycle of gnt per beat. The outgoing master loses gnt on the same edge the incoming master gains it.
- Simultaneous events: the owner dropping req on the same edge as the burst limit is reached is treated as a normal release → OWNy.
- Reset mid-write: bus_we falls as soon as rst_n goes low (through the grant). A partial write is never repeated after reset.
- MAX_BURST=1: strict alternation whenever both masters request.

Decomposition:
- Package bus_pkg:
  - arb_state_t enum {IDLE, OWN0, OWN1}.
  - Memory-map localparams BEGINMEM=12'h000, ENDMEM=12'h1ff, BUTTONDATA=12'h900, BUTTONCHOICE=12'h901, SEVENSEG=12'hb00, shared with the top-level decode.
- No sub-module: the FSM, counter and output mux fit in one module.

Test Plan:
- Reset then m0_req=1, m0_we=1, m0_addr=0x010, m0_wdata=0x1234 at cycle 0 → m0_gnt=1 at cycle 1; bus_we=1, bus_addr=0x010 at cycle 1; RAM[0x010]=0x1234 after that edge.
- Both req from cycle 0, MAX_BURST=4 → m0_gnt cycles 1–4, m1_gnt cycles 5–8, m0_gnt cycles 9–12; never both high.
- m1 alone, reading 0x900 with button_in=0x0005 → m1_gnt next cycle, m1_rdata=0x0005 in that beat; bus_we=0.
- m0 owns, drops req at cycle 3, m1 requesting → m1_gnt at cycle 4, no IDLE cycle; cnt restarts at 0.
- m0 granted, m0_req=0, m0_we=1 in the same cycle → bus_we=0 that cycle; state IDLE next cycle.
- rst_n low mid-burst during m1 write to 0xB00 → m1_gnt and bus_we drop immediately; after release with both requesting, m0 is granted first.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the processor bus: arbiter state encoding and the
// memory map used by the top-level address decode.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [11:0] BEGINMEM     = 12'h000;
  localparam logic [11:0] ENDMEM       = 12'h1ff;
  localparam logic [11:0] BUTTONDATA   = 12'h900;
  localparam logic [11:0] BUTTONCHOICE = 12'h901;
  localparam logic [11:0] SEVENSEG     = 12'hb00;

  function automatic arb_state_t own_state(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared processor bus with a bounded
// burst length; grants come straight from registered state.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_owner
);

  localparam int             CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST - 1);

  arb_state_t    state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          owner_nxt;
  logic [1:0]    req;
  logic          cur;
  logic          enter;
  logic          enter_idx;

  assign req = {m1_req, m0_req};
  assign cur = (state == OWN1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      bus_owner <= 1'b0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      bus_owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    owner_nxt = bus_owner;
    enter     = 1'b0;
    enter_idx = 1'b0;
    case (state)
      IDLE: begin
        if (req == 2'b11) begin
          enter     = 1'b1;
          enter_idx = ~last;
        end else if (req != 2'b00) begin
          enter     = 1'b1;
          enter_idx = req[1];
        end
      end
      OWN0, OWN1: begin
        if (!req[cur]) begin
          if (req[~cur]) begin
            enter     = 1'b1;
            enter_idx = ~cur;
          end else begin
            state_nxt = IDLE;
          end
        end else if (req[~cur] && cnt == CNT_MAX) begin
          // burst limit reached with the other master waiting: hand over, no gap
          enter     = 1'b1;
          enter_idx = ~cur;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (enter) begin
      state_nxt = own_state(enter_idx);
      last_nxt  = enter_idx;
      cnt_nxt   = '0;
      owner_nxt = enter_idx;
    end
  end

  assign m0_gnt = (state == OWN0);
  assign m1_gnt = (state == OWN1);

  // A granted master that has dropped req must never strobe a write.
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    case (state)
      OWN0: begin
        bus_addr  = m0_addr;
        bus_wdata = m0_wdata;
        bus_we    = m0_we & m0_req;
      end
      OWN1: begin
        bus_addr  = m1_addr;
        bus_wdata = m1_wdata;
        bus_we    = m1_we & m1_req;
      end
      default: ;
    endcase
  end

  assign m0_rdata = bus_rdata;
  assign m1_rdata = bus_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: fixed vector table, directed corner cases, and a
// randomized run against an owner/run-length reference model (MAX_BURST 4 and 1).
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;

  logic          a_g0, a_g1, a_we, a_own;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rd0, a_rd1, a_rdata;
  logic          b_g0, b_g1, b_we, b_own;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rd0, b_rd1, b_rdata;

  logic [DW-1:0] ram [0:511];
  logic [DW-1:0] button_in;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_g0), .m0_rdata(a_rd0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_g1), .m1_rdata(a_rd1),
    .bus_addr(a_addr), .bus_wdata(a_wdata), .bus_we(a_we),
    .bus_rdata(a_rdata), .bus_owner(a_own));

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_g0), .m0_rdata(b_rd0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_g1), .m1_rdata(b_rd1),
    .bus_addr(b_addr), .bus_wdata(b_wdata), .bus_we(b_we),
    .bus_rdata(b_rdata), .bus_owner(b_own));

  // Decode in front of instance A: RAM, button, otherwise zero.
  always_comb begin
    a_rdata = '0;
    if (a_addr <= ENDMEM)          a_rdata = ram[a_addr[8:0]];
    else if (a_addr == BUTTONDATA) a_rdata = button_in;
  end

  always @(posedge clk)
    if (a_we && a_addr <= ENDMEM) ram[a_addr[8:0]] <= a_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 = nobody), last winner, beats in current tenure.
  int own [2];
  int lst [2];
  int run [2];
  int mb  [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      own[k] = -1; lst[k] = 1; run[k] = 0;
    end
    mb[0] = 4; mb[1] = 1;
  endtask

  task automatic model_check();
    logic [1:0] r, w;
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic g0, g1, we, ow;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rd0, rd1, rsrc;
    r = {m1_req, m0_req}; w = {m1_we, m0_we};
    ad[0] = m0_addr; ad[1] = m1_addr; wd[0] = m0_wdata; wd[1] = m1_wdata;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        g0 = a_g0; g1 = a_g1; we = a_we; ow = a_own; addr = a_addr; wdata = a_wdata;
        rd0 = a_rd0; rd1 = a_rd1; rsrc = a_rdata;
      end else begin
        g0 = b_g0; g1 = b_g1; we = b_we; ow = b_own; addr = b_addr; wdata = b_wdata;
        rd0 = b_rd0; rd1 = b_rd1; rsrc = b_rdata;
      end
      chk($sformatf("rand%0d gnt", k), {g1, g0}, {own[k] == 1, own[k] == 0});
      if (own[k] < 0) begin
        chk($sformatf("rand%0d idle_bus", k), {we, addr, wdata}, '0);
      end else begin
        chk($sformatf("rand%0d we", k), we, w[own[k]] & r[own[k]]);
        chk($sformatf("rand%0d addr", k), addr, ad[own[k]]);
        chk($sformatf("rand%0d wdata", k), wdata, wd[own[k]]);
        chk($sformatf("rand%0d owner", k), ow, own[k]);
      end
      chk($sformatf("rand%0d rdata", k), {rd1, rd0}, {rsrc, rsrc});
    end
  endtask

  task automatic model_step();
    int r [2];
    int x, y, nxt, now;
    r[0] = m0_req; r[1] = m1_req;
    for (int k = 0; k < 2; k++) begin
      x = own[k];
      if (x < 0) begin
        if (r[0] && r[1]) nxt = 1 - lst[k];
        else if (r[0])    nxt = 0;
        else if (r[1])    nxt = 1;
        else              nxt = -1;
        now = 0;
      end else begin
        y = 1 - x;
        now = run[k] + r[x];
        if (!r[x])                      nxt = r[y] ? y : -1;
        else if (r[y] && now >= mb[k])  nxt = y;
        else                            nxt = x;
      end
      if (nxt != x) begin
        run[k] = 0;
        if (nxt >= 0) lst[k] = nxt;
      end else begin
        run[k] = now;
      end
      own[k] = nxt;
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    chk("reset gnt_a", {a_g1, a_g0}, 2'b00);
    chk("reset gnt_b", {b_g1, b_g0}, 2'b00);
    chk("reset bus_a", {a_we, a_own, a_addr, a_wdata}, '0);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic r0, w0, r1, w1;
    logic g0, g1, we;
  } vec_t;
  vec_t tbl [28];

  initial begin
    idle_inputs();
    button_in = '0;
    b_rdata = '0;
    for (int i = 0; i < 512; i++) ram[i] = '0;
    model_reset();

    // Vector table for MAX_BURST=4, outputs observed in the same cycle.
    for (int i = 0; i <= 12; i++)
      tbl[i] = '{1, 0, 1, 0, (i >= 1 && i <= 4) || i >= 9, i >= 5 && i <= 8, 0};
    tbl[13] = '{1, 1, 0, 0, 0, 1, 0};
    tbl[14] = '{1, 1, 0, 0, 1, 0, 1};
    tbl[15] = '{0, 1, 0, 0, 1, 0, 0};
    tbl[16] = '{0, 0, 1, 1, 0, 0, 0};
    tbl[17] = '{0, 0, 1, 1, 0, 1, 1};
    tbl[18] = '{1, 0, 0, 1, 0, 1, 0};
    for (int i = 19; i <= 25; i++) tbl[i] = '{1, 0, 0, 0, 1, 0, 0};
    tbl[26] = '{1, 0, 1, 0, 1, 0, 0};
    tbl[27] = '{1, 0, 1, 0, 0, 1, 0};

    do_reset();
    m0_addr = 12'h020; m1_addr = 12'h030;
    for (int i = 0; i < 28; i++) begin
      m0_req = tbl[i].r0; m0_we = tbl[i].w0; m1_req = tbl[i].r1; m1_we = tbl[i].w1;
      @(negedge clk);
      chk($sformatf("vec%0d gnt", i), {a_g1, a_g0}, {tbl[i].g1, tbl[i].g0});
      chk($sformatf("vec%0d we", i), a_we, tbl[i].we);
      @(posedge clk); #1;
    end

    // Single write to RAM from master 0.
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 12'h010; m0_wdata = 16'h1234;
    @(posedge clk); #1;
    chk("wr gnt", a_g0, 1'b1);
    chk("wr we_addr", {a_we, a_addr}, {1'b1, 12'h010});
    @(posedge clk); #1;
    chk("wr ram", ram[16], 16'h1234);

    // Master 1 reads the button register.
    do_reset();
    button_in = 16'h0005;
    m1_req = 1; m1_we = 0; m1_addr = BUTTONDATA;
    @(posedge clk); #1;
    chk("btn gnt", a_g1, 1'b1);
    chk("btn rdata", a_rd1, 16'h0005);
    chk("btn we", a_we, 1'b0);

    // Reset asserted mid-write: grant and strobe drop without a clock edge.
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = SEVENSEG; m1_wdata = 16'h00ff;
    @(posedge clk); #1;
    chk("rstw gnt", {a_g1, a_we}, 2'b11);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rstw drop", {a_g1, a_we, b_g1, b_we}, 4'b0000);
    m0_req = 1; m0_we = 0; m1_we = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstw first_a", {a_g1, a_g0}, 2'b01);
    chk("rstw first_b", {b_g1, b_g0}, 2'b01);

    // Randomized run against the reference model, with shifting request density.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens = ((i / 150) % 3) + 1;
      m0_req = ($urandom_range(3) < dens);
      m1_req = ($urandom_range(3) < dens);
      m0_we = $urandom_range(1); m1_we = $urandom_range(1);
      m0_addr = AW'($urandom); m1_addr = AW'($urandom);
      m0_wdata = DW'($urandom); m1_wdata = DW'($urandom);
      button_in = DW'($urandom);
      b_rdata = DW'($urandom);
      @(negedge clk);
      model_check();
      model_step();
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
